// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the instruction fetcher   |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package fetch_pkg;

  localparam int c_INSTR_W         = 32;
  localparam int c_ADDR_W          = 64;
  localparam int c_DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  // Bit 0 is the MSB; 32-bit mode clears the upper half of the address.
  function automatic logic [0:c_ADDR_W-1] mask_addr(input logic [0:c_ADDR_W-1] addr,
                                                    input logic                  mode32);
    logic [0:c_ADDR_W-1] w_masked;
    w_masked = addr;
    if (mode32) begin
      w_masked[0:c_ADDR_W/2-1] = '0;
    end
    return w_masked;
  endfunction

  function automatic logic is_aligned(input logic [0:c_ADDR_W-1] addr);
    return addr[c_ADDR_W-2:c_ADDR_W-1] == 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_if : memory read request/response bus of the fetcher     |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
interface instr_fetch_if;
  import fetch_pkg::*;

  logic                  mem_req_valid;
  logic [0:c_ADDR_W-1]   mem_req_addr;
  logic                  mem_req_ready;
  logic                  mem_rsp_valid;
  logic [0:c_INSTR_W-1]  mem_rsp_data;
  logic                  mem_rsp_err;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data,
    input  mem_rsp_err
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data,
    output mem_rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch : single-outstanding instruction fetch FSM with timeout  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT
) (
  input  wire logic                  i_clk,
  input  wire logic                  i_rst_n,
  input  wire logic                  i_32b_mode,
  input  wire logic [0:c_ADDR_W-1]   i_next_instr_addr,
  output logic                       o_stall,
  instr_fetch_if.master              mem,
  output logic [0:c_INSTR_W-1]       o_instr,
  output logic                       o_instr_valid,
  input  wire logic                  i_instr_ready,
  output logic                       o_fetch_err,
  output logic [0:c_ADDR_W-1]        o_fetch_addr
);

  localparam int               c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  fetch_state_t           r_state;
  logic [0:c_ADDR_W-1]    r_addr;
  logic [0:c_INSTR_W-1]   r_instr;
  logic                   r_instr_valid;
  logic                   r_req_valid;
  logic                   r_fetch_err;
  logic [c_CNT_W-1:0]     r_cnt;

  logic [0:c_ADDR_W-1]    w_addr_masked;
  logic                   w_next_aligned;

  assign w_addr_masked  = mask_addr(r_addr, i_32b_mode);
  assign w_next_aligned = is_aligned(i_next_instr_addr);

  assign o_stall           = !((r_state == S_HOLD) && i_instr_ready);
  assign mem.mem_req_valid = r_req_valid;
  assign mem.mem_req_addr  = w_addr_masked;
  assign o_instr           = r_instr;
  assign o_instr_valid     = r_instr_valid;
  assign o_fetch_err       = r_fetch_err;
  assign o_fetch_addr      = w_addr_masked;

  // Request valid is computed while loading the address so a misaligned
  // fetch never raises it, even for the single REQ cycle it spends there.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_req_valid   <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_fetch_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_addr      <= i_next_instr_addr;
          r_req_valid <= w_next_aligned;
          r_state     <= S_REQ;
        end
        S_REQ: begin
          if (!is_aligned(r_addr)) begin
            r_fetch_err <= 1'b1;
            r_state     <= S_IDLE;
          end else if (mem.mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.mem_rsp_valid && !mem.mem_rsp_err) begin
            r_instr       <= mem.mem_rsp_data;
            r_instr_valid <= 1'b1;
            r_state       <= S_HOLD;
          end else if (mem.mem_rsp_valid || (r_cnt == c_CNT_LAST)) begin
            r_fetch_err <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (i_instr_ready) begin
            r_instr_valid <= 1'b0;
            r_addr        <= i_next_instr_addr;
            r_req_valid   <= w_next_aligned;
            r_state       <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_fetch : scoreboard bench for instr_fetch                    |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_instr_fetch;
  import fetch_pkg::*;

  typedef struct {
    bit          is_err;
    logic [31:0] instr;
    logic [63:0] addr;
  } exp_t;

  logic        r_clk = 1'b0;
  logic        r_rst_n;
  logic        r_32b_mode;
  logic [0:63] r_next_addr;
  logic        r_instr_ready;
  logic        w_stall;
  logic [0:31] w_instr;
  logic        w_instr_valid;
  logic        w_fetch_err;
  logic [0:63] w_fetch_addr;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  exp_t r_exp;

  instr_fetch_if u_if ();

  instr_fetch #(.TIMEOUT_CYCLES(255)) u_dut (
    .i_clk             (r_clk),
    .i_rst_n           (r_rst_n),
    .i_32b_mode        (r_32b_mode),
    .i_next_instr_addr (r_next_addr),
    .o_stall           (w_stall),
    .mem               (u_if),
    .o_instr           (w_instr),
    .o_instr_valid     (w_instr_valid),
    .i_instr_ready     (r_instr_ready),
    .o_fetch_err       (w_fetch_err),
    .o_fetch_addr      (w_fetch_addr)
  );

  always #5 r_clk = ~r_clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge r_clk);
    #1;
  endtask

  task automatic push_exp(input bit err, input logic [31:0] data, input logic [63:0] addr);
    exp_q.push_back('{is_err: err, instr: data, addr: addr});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_stall"},     64'(w_stall),               64'd1);
    check_val({tag, "_req_valid"}, 64'(u_if.mem_req_valid),    64'd0);
    check_val({tag, "_ivalid"},    64'(w_instr_valid),         64'd0);
    check_val({tag, "_err"},       64'(w_fetch_err),           64'd0);
    check_val({tag, "_req_addr"},  64'(u_if.mem_req_addr),     64'd0);
    check_val({tag, "_faddr"},     64'(w_fetch_addr),          64'd0);
    check_val({tag, "_instr"},     64'(w_instr),               64'd0);
  endtask

  // Waits for the request handshake, then answers after 'delay' WAIT cycles.
  task automatic serve(input int delay, input logic [31:0] data, input bit err);
    int n = 0;
    while (!(u_if.mem_req_valid && u_if.mem_req_ready) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check_val("req_handshake_timeout", 64'd0, 64'd1);
    step();
    repeat (delay) step();
    u_if.mem_rsp_valid = 1'b1;
    u_if.mem_rsp_data  = data;
    u_if.mem_rsp_err   = err;
    step();
    u_if.mem_rsp_valid = 1'b0;
    u_if.mem_rsp_err   = 1'b0;
  endtask

  task automatic consume(input logic [63:0] next);
    r_next_addr   = next;
    r_instr_ready = 1'b1;
    step();
    r_instr_ready = 1'b0;
  endtask

  // Scoreboard: every delivered instruction or error pulse pops one entry.
  always @(negedge r_clk) begin
    if (r_rst_n && ((w_instr_valid && r_instr_ready) || w_fetch_err)) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected", 64'(w_fetch_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        r_exp = exp_q.pop_front();
        check_val("sb_kind", 64'(w_fetch_err), 64'(r_exp.is_err));
        check_val("sb_addr", 64'(w_fetch_addr), r_exp.addr);
        if (!r_exp.is_err) check_val("sb_instr", 64'(w_instr), 64'(r_exp.instr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    r_rst_n            = 1'b0;
    r_32b_mode         = 1'b0;
    r_next_addr        = '0;
    r_instr_ready      = 1'b0;
    u_if.mem_req_ready = 1'b1;
    u_if.mem_rsp_valid = 1'b0;
    u_if.mem_rsp_data  = '0;
    u_if.mem_rsp_err   = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst");

    // Basic fetch from address 0 with a next-cycle response
    r_rst_n = 1'b1;
    check_val("idle_req_valid", 64'(u_if.mem_req_valid), 64'd0);
    step();
    check_val("req_valid", 64'(u_if.mem_req_valid), 64'd1);
    check_val("req_addr0", 64'(u_if.mem_req_addr), 64'd0);
    push_exp(1'b0, 32'h4800_0010, 64'h0);
    serve(0, 32'h4800_0010, 1'b0);
    check_val("hold_ivalid", 64'(w_instr_valid), 64'd1);
    check_val("hold_instr", 64'(w_instr), 64'h4800_0010);
    check_val("hold_faddr", 64'(w_fetch_addr), 64'h0);

    // Downstream back-pressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      check_val("bp_stall", 64'(w_stall), 64'd1);
      check_val("bp_instr", 64'(w_instr), 64'h4800_0010);
      step();
    end
    r_next_addr   = 64'h2000;
    r_instr_ready = 1'b1;
    #1;
    check_val("consume_stall", 64'(w_stall), 64'd0);
    step();
    r_instr_ready = 1'b0;
    check_val("after_stall", 64'(w_stall), 64'd1);
    check_val("next_req_valid", 64'(u_if.mem_req_valid), 64'd1);
    check_val("next_req_addr", 64'(u_if.mem_req_addr), 64'h2000);
    push_exp(1'b0, 32'h6000_0000, 64'h2000);
    serve(2, 32'h6000_0000, 1'b0);

    // Misaligned next address
    consume(64'h1002);
    push_exp(1'b1, 32'h0, 64'h1002);
    check_val("mis_no_req", 64'(u_if.mem_req_valid), 64'd0);
    step();
    check_val("mis_err", 64'(w_fetch_err), 64'd1);
    check_val("mis_no_req2", 64'(u_if.mem_req_valid), 64'd0);
    r_next_addr = 64'h3000;
    step();
    check_val("mis_err_pulse", 64'(w_fetch_err), 64'd0);

    // Bus error on the response
    push_exp(1'b1, 32'h0, 64'h3000);
    serve(1, 32'h1234_5678, 1'b1);
    check_val("buserr_ivalid", 64'(w_instr_valid), 64'd0);

    // 32-bit mode masks the upper address half
    r_32b_mode  = 1'b1;
    r_next_addr = 64'hFFFF_FFFF_0000_0100;
    step();
    check_val("m32_req_addr", 64'(u_if.mem_req_addr), 64'h100);
    push_exp(1'b0, 32'h7C08_02A6, 64'h100);
    serve(0, 32'h7C08_02A6, 1'b0);
    consume(64'h4000);
    r_32b_mode = 1'b0;

    // Timeout after 255 silent WAIT cycles, late response ignored
    push_exp(1'b1, 32'h0, 64'h4000);
    check_val("to_req_addr", 64'(u_if.mem_req_addr), 64'h4000);
    step();
    repeat (254) step();
    check_val("to_not_yet", 64'(w_fetch_err), 64'd0);
    step();
    check_val("to_err", 64'(w_fetch_err), 64'd1);
    u_if.mem_rsp_valid = 1'b1;
    u_if.mem_rsp_data  = 32'hBAD0_0001;
    u_if.mem_req_ready = 1'b0;
    r_next_addr        = 64'h5000;
    step();
    u_if.mem_rsp_valid = 1'b0;
    check_val("late_ivalid", 64'(w_instr_valid), 64'd0);
    check_val("late_err", 64'(w_fetch_err), 64'd0);

    // Request held stable while memory is not ready
    for (int i = 0; i < 3; i++) begin
      check_val("stable_valid", 64'(u_if.mem_req_valid), 64'd1);
      check_val("stable_addr", 64'(u_if.mem_req_addr), 64'h5000);
      step();
    end
    u_if.mem_req_ready = 1'b1;
    push_exp(1'b0, 32'h3860_0001, 64'h5000);
    serve(0, 32'h3860_0001, 1'b0);

    // Reset in WAIT abandons the outstanding fetch
    consume(64'h6000);
    step();
    r_rst_n = 1'b0;
    step();
    check_reset_outputs("midrst");
    r_rst_n            = 1'b1;
    r_next_addr        = 64'h7000;
    u_if.mem_rsp_valid = 1'b1;
    u_if.mem_rsp_data  = 32'hDEAD_BEEF;
    step();
    u_if.mem_rsp_valid = 1'b0;
    check_val("midrst_ivalid", 64'(w_instr_valid), 64'd0);
    check_val("midrst_req_addr", 64'(u_if.mem_req_addr), 64'h7000);
    push_exp(1'b0, 32'h4E80_0020, 64'h7000);
    serve(1, 32'h4E80_0020, 1'b0);
    consume(64'h8000);

    step();
    check_val("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of WAIT cycles before a fetch is abandoned.
REQ-002 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 i_rst_n  in  1  reset, synchronous, active-low.
REQ-004 i_32b_mode  in  1  when 1, address bits [0:31] forced to 0 on the memory request.
REQ-005 i_next_instr_addr  in  64 [0:63]  next instruction address from the branch unit.
REQ-006 o_stall  out  1  to the branch unit; 1 = do not update the current instruction address.
REQ-007 o_mem_req_valid  out  1  memory read request valid.
REQ-008 o_mem_req_addr  out  64 [0:63]  memory read word address.
REQ-009 i_mem_req_ready  in  1  memory accepts the request.
REQ-010 i_mem_rsp_valid  in  1  read data valid.
REQ-011 i_mem_rsp_data  in  32 [0:31]  instruction word.
REQ-012 i_mem_rsp_err  in  1  bus error qualifying i_mem_rsp_valid.
REQ-013 o_instr  out  32 [0:31]  fetched instruction to identify/branch unit.
REQ-014 o_instr_valid  out  1  o_instr holds a valid instruction.
REQ-015 i_instr_ready  in  1  downstream consumes o_instr this cycle.
REQ-016 o_fetch_err  out  1  one-cycle pulse: misaligned address, bus error or timeout.
REQ-017 o_fetch_addr  out  64 [0:63]  address of the instruction in o_instr / the faulting fetch.

Function
REQ-018 FSM states: IDLE, REQ, WAIT, HOLD; at most one request outstanding.
REQ-019 IDLE: o_stall=1; next cycle latches i_next_instr_addr into addr_q and enters REQ.
REQ-020 REQ: o_mem_req_valid=1, o_mem_req_addr=addr_q (upper 32 bits zero if i_32b_mode); addr_q and o_mem_req_addr stay stable until i_mem_req_ready; on valid&ready enter WAIT.
REQ-021 Misaligned addr_q (bits [62:63] != 0): no request issued; o_fetch_err pulses; FSM returns to IDLE.
REQ-022 WAIT: on i_mem_rsp_valid & ~i_mem_rsp_err capture data into o_instr, enter HOLD; on i_mem_rsp_err pulse o_fetch_err and return to IDLE.
REQ-023 WAIT counter resets on WAIT entry; if TIMEOUT_CYCLES cycles elapse without a response, pulse o_fetch_err and return to IDLE; any late response is ignored.
REQ-024 i_mem_rsp_valid outside WAIT is ignored.
REQ-025 HOLD: o_instr_valid=1, o_instr and o_fetch_addr stable until i_instr_ready.
REQ-026 o_stall = 0 only in the HOLD cycle where i_instr_ready=1; in that cycle addr_q <= i_next_instr_addr and the FSM enters REQ directly (no IDLE bubble).
REQ-027 Consequence: minimum throughput is one instruction per 3 cycles (REQ, WAIT with same-cycle response, HOLD).
REQ-028 o_fetch_addr equals addr_q after the 32-bit mask.

Reset
REQ-029 While i_rst_n=0 at a clock edge: state=IDLE, addr_q=0, o_instr=0, counter=0.
REQ-030 Reset values: o_stall=1, o_mem_req_valid=0, o_instr_valid=0, o_fetch_err=0, o_mem_req_addr=0, o_fetch_addr=0.
REQ-031 Reset mid-operation abandons any outstanding request; a response arriving after reset is ignored.

Structure
REQ-032 Shared package fetch_pkg holds the state enum, the default TIMEOUT_CYCLES and the instruction width (32).
REQ-033 Single module, no sub-modules; timeout counter width is $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-034 Reset release, i_next_instr_addr=0x0, mem ready immediately, response 0x48000010 one cycle later -> o_instr_valid with o_instr=0x48000010, o_fetch_addr=0x0.
REQ-035 HOLD with i_instr_ready=0 for 5 cycles -> o_stall=1 and o_instr stable throughout; ready=1 -> o_stall=0 for exactly one cycle, next request to the new i_next_instr_addr.
REQ-036 i_next_instr_addr=0x1002 -> no o_mem_req_valid, o_fetch_err pulse with o_fetch_addr=0x1002.
REQ-037 i_32b_mode=1, i_next_instr_addr=0xFFFF_FFFF_0000_0100 -> o_mem_req_addr=0x0000_0000_0000_0100.
REQ-038 No response for 255 WAIT cycles -> o_fetch_err pulse, return to IDLE; response on cycle 256 ignored.
REQ-039 i_rst_n=0 during WAIT -> all outputs at reset values next cycle; pending response not delivered.
